// File: rtl/uart_config_initiator.sv
// uart_config_initiator: master-side UART autoconfiguration sequencer with ACK timeout/retry.
module uart_config_initiator #(
  parameter int unsigned COUNT_TIMEOUT = 5_000_000,
  parameter int unsigned MAX_RETRY = 3,
  parameter logic [7:0] REQ_PKT = 8'hF0,
  parameter logic [7:0] ACKN_PKT = 8'hFF,
  parameter logic [5:0] ID_DW = 6'h01,
  parameter logic [5:0] ID_PM = 6'h02,
  parameter logic [5:0] ID_SB = 6'h03,
  parameter logic [5:0] ID_END = 6'h3F,
  parameter logic [1:0] STD_DW = 2'b11,
  parameter logic [1:0] STD_PM = 2'b00,
  parameter logic [1:0] STD_SB = 2'b00
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic [1:0] cfg_dw_i,
  input  logic [1:0] cfg_pm_i,
  input  logic [1:0] cfg_sb_i,
  input  logic       tx_fifo_full_i,
  output logic       tx_fifo_write_o,
  output logic [7:0] data_tx_o,
  input  logic       rx_fifo_empty_i,
  input  logic [7:0] data_rx_i,
  output logic       rx_fifo_read_o,
  output logic       busy_o,
  output logic       data_stream_mode_o,
  output logic       cfg_apply_o,
  output logic [1:0] cfg_dw_o,
  output logic [1:0] cfg_pm_o,
  output logic [1:0] cfg_sb_o,
  output logic       std_config_o,
  output logic       config_error_o
);
  localparam int TW = $clog2(COUNT_TIMEOUT);
  localparam int RW = $clog2(MAX_RETRY + 1);
  typedef enum logic [2:0] {IDLE, SEND, WAIT_ACK, DONE, FAIL} state_t;
  state_t state;
  logic [2:0] index;
  logic [RW-1:0] retry;
  logic [TW-1:0] timer;
  logic [1:0] dw, pm, sb;
  logic [7:0] pkt;
  logic ack, nack, timeout;
  assign pkt = index == 3'd0 ? REQ_PKT : index == 3'd1 ? {ID_DW, dw} :
               index == 3'd2 ? {ID_PM, pm} : index == 3'd3 ? {ID_SB, sb} : {ID_END, 2'b00};
  assign ack = !rx_fifo_empty_i && data_rx_i == ACKN_PKT;
  // a stray byte only aborts once the slave has accepted the request
  assign nack = !rx_fifo_empty_i && data_rx_i != ACKN_PKT && index != 3'd0;
  assign timeout = timer == TW'(COUNT_TIMEOUT - 1);
  assign rx_fifo_read_o = state == WAIT_ACK && !rx_fifo_empty_i;
  assign busy_o = state != IDLE;
  assign data_stream_mode_o = busy_o;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      index <= '0;
      retry <= '0;
      timer <= '0;
      dw <= '0;
      pm <= '0;
      sb <= '0;
      tx_fifo_write_o <= 1'b0;
      data_tx_o <= '0;
      cfg_apply_o <= 1'b0;
      cfg_dw_o <= '0;
      cfg_pm_o <= '0;
      cfg_sb_o <= '0;
      std_config_o <= 1'b0;
      config_error_o <= 1'b0;
    end else begin
      tx_fifo_write_o <= 1'b0;
      cfg_apply_o <= 1'b0;
      std_config_o <= 1'b0;
      case (state)
        IDLE: if (start_i) begin
          dw <= cfg_dw_i;
          pm <= cfg_pm_i;
          sb <= cfg_sb_i == 2'b11 ? STD_SB : cfg_sb_i;
          config_error_o <= cfg_sb_i == 2'b11;
          index <= '0;
          retry <= '0;
          state <= SEND;
        end
        SEND: if (!tx_fifo_full_i) begin
          tx_fifo_write_o <= 1'b1;
          data_tx_o <= pkt;
          timer <= '0;
          state <= WAIT_ACK;
        end
        WAIT_ACK: begin
          timer <= timer + 1'b1;
          if (ack) begin
            retry <= '0;
            if (index == 3'd4) begin
              cfg_apply_o <= 1'b1;
              cfg_dw_o <= dw;
              cfg_pm_o <= pm;
              cfg_sb_o <= sb;
              state <= DONE;
            end else begin
              index <= index + 3'd1;
              state <= SEND;
            end
          end else if (nack || (timeout && retry == RW'(MAX_RETRY))) begin
            config_error_o <= 1'b1;
            std_config_o <= 1'b1;
            cfg_dw_o <= STD_DW;
            cfg_pm_o <= STD_PM;
            cfg_sb_o <= STD_SB;
            state <= FAIL;
          end else if (timeout) begin
            retry <= retry + 1'b1;
            state <= SEND;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_config_initiator.sv
// tb_uart_config_initiator: scoreboarded directed test with an ACK-responding RX FIFO model.
module tb_uart_config_initiator;
  localparam int TO = 100;
  logic clk = 1'b0;
  logic rst_i = 1'b1;
  logic start_i = 1'b0;
  logic [1:0] cfg_dw_i = '0, cfg_pm_i = '0, cfg_sb_i = '0;
  logic tx_fifo_full_i = 1'b0;
  logic tx_fifo_write_o, rx_fifo_read_o, busy_o, data_stream_mode_o;
  logic cfg_apply_o, std_config_o, config_error_o;
  logic [7:0] data_tx_o;
  logic [1:0] cfg_dw_o, cfg_pm_o, cfg_sb_o;
  logic rx_fifo_empty_i = 1'b1;
  logic [7:0] data_rx_i = '0;
  int vectors = 0, errors = 0;
  int cyc = 0, start_cyc = 0, dly = 0, pend = 0;
  int n_apply = 0, n_std = 0, b_wr = 0, b_ap = 0, b_std = 0;
  logic rd_edge = 1'b0;
  logic [5:0] ap_cfg = '0;
  logic [7:0] exp_tx[$];
  logic [7:0] rxq[$];
  int resp_q[$];
  int wr_cyc[$];

  uart_config_initiator #(.COUNT_TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i),
    .cfg_dw_i(cfg_dw_i), .cfg_pm_i(cfg_pm_i), .cfg_sb_i(cfg_sb_i),
    .tx_fifo_full_i(tx_fifo_full_i), .tx_fifo_write_o(tx_fifo_write_o), .data_tx_o(data_tx_o),
    .rx_fifo_empty_i(rx_fifo_empty_i), .data_rx_i(data_rx_i), .rx_fifo_read_o(rx_fifo_read_o),
    .busy_o(busy_o), .data_stream_mode_o(data_stream_mode_o), .cfg_apply_o(cfg_apply_o),
    .cfg_dw_o(cfg_dw_o), .cfg_pm_o(cfg_pm_o), .cfg_sb_o(cfg_sb_o),
    .std_config_o(std_config_o), .config_error_o(config_error_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    rd_edge = rx_fifo_read_o;
  end

  // RX FIFO model, scoreboard pop and delayed ACK responder
  always @(negedge clk) begin
    if (rst_i) begin
      rxq.delete();
      dly = 0;
    end else begin
      if (rd_edge && rxq.size() > 0) void'(rxq.pop_front());
      if (tx_fifo_write_o) begin
        wr_cyc.push_back(cyc);
        chk("tx_data", {8'h00, data_tx_o}, exp_tx.size() > 0 ? {8'h00, exp_tx.pop_front()} : 16'h0100);
        if (resp_q.size() > 0) begin
          pend = resp_q.pop_front();
          dly = 5;
        end
      end
      if (dly > 0) begin
        dly--;
        if (dly == 0) begin
          if (pend > 255) rxq.push_back(pend[15:8]);
          rxq.push_back(pend[7:0]);
        end
      end
      if (cfg_apply_o) begin
        n_apply++;
        ap_cfg = {cfg_dw_o, cfg_pm_o, cfg_sb_o};
      end
      if (std_config_o) n_std++;
    end
    rx_fifo_empty_i = rxq.size() == 0;
    data_rx_i = rxq.size() > 0 ? rxq[0] : 8'h00;
  end

  task automatic snap();
    b_wr = wr_cyc.size();
    b_ap = n_apply;
    b_std = n_std;
  endtask

  task automatic start_seq(input logic [1:0] dw, input logic [1:0] pm, input logic [1:0] sb);
    snap();
    @(negedge clk);
    start_cyc = cyc;
    cfg_dw_i = dw;
    cfg_pm_i = pm;
    cfg_sb_i = sb;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (!busy_o) break;
    end
    chk("idle", {15'd0, busy_o}, 16'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy", {15'd0, busy_o}, 16'd0);
    chk("rst_outs", {8'd0, tx_fifo_write_o, cfg_apply_o, std_config_o, config_error_o, rx_fifo_read_o, data_stream_mode_o, 2'd0}, 16'd0);
    chk("rst_data", {8'd0, data_tx_o}, 16'd0);
    rst_i = 1'b0;
    // full successful sequence, with a start pulse while busy that must be ignored
    exp_tx = '{8'hF0, 8'h06, 8'h09, 8'h0C, 8'hFC};
    resp_q = '{'hFF, 'hFF, 'hFF, 'hFF, 'hFF};
    start_seq(2'b10, 2'b01, 2'b00);
    chk("busy", {14'd0, busy_o, data_stream_mode_o}, 16'h3);
    repeat (3) @(negedge clk);
    start_i = 1'b1;
    cfg_dw_i = 2'b00;
    @(negedge clk);
    start_i = 1'b0;
    wait_idle();
    chk("t1_latency", 16'(wr_cyc[b_wr] - start_cyc), 16'd2);
    chk("t1_writes", 16'(wr_cyc.size() - b_wr), 16'd5);
    chk("t1_apply", 16'(n_apply - b_ap), 16'd1);
    chk("t1_cfg", {10'd0, ap_cfg}, 16'b10_01_00);
    chk("t1_std", 16'(n_std - b_std), 16'd0);
    chk("t1_err", {15'd0, config_error_o}, 16'd0);
    // no ACK ever: request sent 1+MAX_RETRY times
    exp_tx = '{8'hF0, 8'hF0, 8'hF0, 8'hF0};
    start_seq(2'b10, 2'b01, 2'b00);
    wait_idle();
    chk("t2_writes", 16'(wr_cyc.size() - b_wr), 16'd4);
    chk("t2_gap", {15'd0, (wr_cyc[b_wr + 1] - wr_cyc[b_wr]) inside {TO, TO + 1}}, 16'd1);
    chk("t2_std", 16'(n_std - b_std), 16'd1);
    chk("t2_apply", 16'(n_apply - b_ap), 16'd0);
    chk("t2_err", {15'd0, config_error_o}, 16'd1);
    // stray byte before the ACK of the request is discarded
    exp_tx = '{8'hF0, 8'h06, 8'h09, 8'h0C, 8'hFC};
    resp_q = '{'h41FF, 'hFF, 'hFF, 'hFF, 'hFF};
    start_seq(2'b10, 2'b01, 2'b00);
    wait_idle();
    chk("t3_writes", 16'(wr_cyc.size() - b_wr), 16'd5);
    chk("t3_apply", 16'(n_apply - b_ap), 16'd1);
    chk("t3_err", {15'd0, config_error_o}, 16'd0);
    chk("t3_rx_drained", {15'd0, rx_fifo_empty_i}, 16'd1);
    // non-ACK after the data-width packet aborts
    exp_tx = '{8'hF0, 8'h06};
    resp_q = '{'hFF, 'h00};
    start_seq(2'b10, 2'b01, 2'b00);
    wait_idle();
    chk("t4_writes", 16'(wr_cyc.size() - b_wr), 16'd2);
    chk("t4_std", 16'(n_std - b_std), 16'd1);
    chk("t4_apply", 16'(n_apply - b_ap), 16'd0);
    chk("t4_err", {15'd0, config_error_o}, 16'd1);
    chk("t4_rx_drained", {15'd0, rx_fifo_empty_i}, 16'd1);
    // reserved stop bits fall back to the standard value
    exp_tx = '{8'hF0, 8'h05, 8'h0A, 8'h0C, 8'hFC};
    resp_q = '{'hFF, 'hFF, 'hFF, 'hFF, 'hFF};
    start_seq(2'b01, 2'b10, 2'b11);
    chk("t5_err_early", {15'd0, config_error_o}, 16'd1);
    wait_idle();
    chk("t5_apply", 16'(n_apply - b_ap), 16'd1);
    chk("t5_cfg", {10'd0, ap_cfg}, 16'b01_10_00);
    chk("t5_err", {15'd0, config_error_o}, 16'd1);
    // TX FIFO full stalls the write, then reset lands in WAIT_ACK
    exp_tx = '{8'hF0};
    tx_fifo_full_i = 1'b1;
    start_seq(2'b10, 2'b01, 2'b11);
    repeat (10) @(negedge clk);
    chk("t6_stalled", 16'(wr_cyc.size() - b_wr), 16'd0);
    tx_fifo_full_i = 1'b0;
    repeat (5) @(negedge clk);
    chk("t6_one_write", 16'(wr_cyc.size() - b_wr), 16'd1);
    rst_i = 1'b1;
    #1;
    chk("t6_rst_outs", {8'd0, busy_o, tx_fifo_write_o, cfg_apply_o, std_config_o, config_error_o, rx_fifo_read_o, data_stream_mode_o, 1'b0}, 16'd0);
    chk("t6_rst_data", {8'd0, data_tx_o}, 16'd0);
    repeat (3) @(negedge clk);
    rst_i = 1'b0;
    repeat (2 * TO) @(negedge clk);
    chk("t6_no_pulses", 16'((n_apply - b_ap) + (n_std - b_std)), 16'd0);
    chk("t6_writes", 16'(wr_cyc.size() - b_wr), 16'd1);
    chk("t6_sb_left", 16'(exp_tx.size()), 16'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/uart_config_initiator.md
Name: uart_config_initiator

Overview:
- Master-side sequencer for UART autoconfiguration; the initiator of the config-request/ACK exchange that the slave side answers.
- On a CPU start pulse it transmits a request packet, waits for ACK, then sends data-width, parity and stop-bit packets and an end packet, each ACK-gated with timeout/retry.
- Sits between CPU config registers and TX/RX FIFOs.
- Drives the config register update on success, or a standard-config fallback on failure.

Parameters:
- COUNT_TIMEOUT, 5_000_000, ACK wait window in clk cycles (50 ms @ 100 MHz).
- MAX_RETRY, 3, retransmissions allowed per packet before failure.
- REQ_PKT, 8'hF0, configuration request packet.
- ACKN_PKT, 8'hFF, acknowledge packet.
- ID_DW / ID_PM / ID_SB / ID_END, 6'h01 / 6'h02 / 6'h03 / 6'h3F, packet id field values.
- STD_DW / STD_PM / STD_SB, 2'b11 / 2'b00 / 2'b00, standard configuration fields.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous reset, active-high
- start_i  in  1  one-cycle pulse; begin sequence (ignored unless IDLE)
- cfg_dw_i  in  2  requested data width
- cfg_pm_i  in  2  requested parity mode
- cfg_sb_i  in  2  requested stop bits; 2'b11 reserved
- tx_fifo_full_i  in  1  TX FIFO full
- tx_fifo_write_o  out  1  TX FIFO write strobe
- data_tx_o  out  8  packet to write
- rx_fifo_empty_i  in  1  RX FIFO empty
- data_rx_i  in  8  RX FIFO head (show-ahead, valid when !rx_fifo_empty_i)
- rx_fifo_read_o  out  1  RX FIFO pop strobe
- busy_o  out  1  sequence in progress
- data_stream_mode_o  out  1  suppress per-packet RX interrupts; equals busy_o
- cfg_apply_o  out  1  one-cycle pulse: load cfg_dw_o/cfg_pm_o/cfg_sb_o into config register
- cfg_dw_o / cfg_pm_o / cfg_sb_o  out  2 each  configuration to apply
- std_config_o  out  1  one-cycle pulse: load standard configuration
- config_error_o  out  1  sticky; cleared on start_i accepted

Behaviour:
- Packet format: [7:2] id, [1:0] option. Sequence index 0..4 selects REQ_PKT, {ID_DW,dw}, {ID_PM,pm}, {ID_SB,sb}, {ID_END,2'b00}.
- Reset: all outputs 0, state IDLE, index 0, retry counter 0, timer 0.
- Inputs are latched into internal registers on the accepted start_i cycle. If cfg_sb_i == 2'b11, STD_SB is latched instead and config_error_o is set.
- States and transitions:
  - IDLE: start_i -> SEND; busy_o=1 from the next cycle.
  - SEND: if tx_fifo_full_i, hold with no write. Otherwise tx_fifo_write_o=1 with data_tx_o = packet[index] for exactly one cycle, clear timer, -> WAIT_ACK.
  - WAIT_ACK: timer increments every cycle.
    - If !rx_fifo_empty_i: rx_fifo_read_o=1 that cycle.
    - Head == ACKN_PKT: clear retry counter. If index == 4 -> DONE; else index+1 -> SEND.
    - Head != ACKN_PKT at index 0: discard, keep waiting; timer not reset.
    - Head != ACKN_PKT at index >0: set config_error_o -> FAIL.
    - Else if timer == COUNT_TIMEOUT-1: retry+1 -> SEND (same index). If retry == MAX_RETRY already: set config_error_o -> FAIL.
    - ACK arriving on the timeout cycle wins over the timeout.
  - DONE: cfg_apply_o=1 one cycle with the latched fields -> IDLE.
  - FAIL: std_config_o=1 one cycle -> IDLE.
- Total transmissions per packet ≤ 1+MAX_RETRY.
- Outputs are registered from state. Latency from start_i to first tx_fifo_write_o is 2 cycles when the FIFO is not full.
- start_i while busy: ignored. Reset mid-sequence: immediate return to IDLE; no apply or std pulse.
- Timer width is $clog2(COUNT_TIMEOUT); no wrap occurs because it is cleared on every SEND.

Test Plan:
- COUNT_TIMEOUT=100, start with dw=2'b10, pm=2'b01, sb=2'b00; ACK each write after 5 cycles -> writes F0,06,09,0C,FC; cfg_apply_o pulse with 10/01/00; config_error_o=0.
- No ACK ever -> F0 written 4 times, 100 cycles apart; std_config_o pulse; config_error_o=1; busy_o=0 after.
- During REQ wait, RX holds 8'h41 then ACKN_PKT -> 8'h41 popped and ignored; sequence continues to 06.
- After the DW packet, RX returns 8'h00 -> popped; FAIL; std_config_o pulse; no cfg_apply_o.
- sb=2'b11 requested -> stop packet sent as 0C, config_error_o=1 from start; cfg_apply_o still pulses on success.
- tx_fifo_full_i held 10 cycles during SEND -> no write until deasserted, then a single write. Assert rst_i in WAIT_ACK -> all outputs 0 asynchronously, no pulses.
